// File: rtl/multi_ported_sram_pkg.sv
// Shared definitions for the multi-ported memory client: FSM state encoding
// and default port counts / geometry.
package multi_ported_sram_pkg;

    localparam int DEF_NUM_R = 3;
    localparam int DEF_NUM_W = 3;
    localparam int DEF_W     = 32;
    localparam int DEF_N     = 1024;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        KICK,
        WAIT,
        DONE
    } client_state_t;

endpackage

// File: rtl/mp_client_rsp_fifo.sv
// Two-entry read-response buffer; capacity is guaranteed by the caller's credit
// check, so push on a full FIFO only ever coincides with a pop.
module mp_client_rsp_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_occ;
    logic         w_pop;

    assign w_pop = i_pop && (r_occ != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_vld  = (r_occ != 2'd0);
    assign o_dout = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/multi_ported_mem_client_3r3w.sv
// Initiator side of a multi-ported memory: maps valid/ready request streams onto
// memory strobes, buffers read data per port, arbitrates write collisions, sequences init.
module multi_ported_mem_client_3r3w
    import multi_ported_sram_pkg::*;
#(
    parameter int NUM_R = DEF_NUM_R,
    parameter int NUM_W = DEF_NUM_W,
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    localparam int AW   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_R-1:0]    rd_req_vld,
    input  logic [NUM_R*AW-1:0] rd_req_addr,
    output logic [NUM_R-1:0]    rd_req_rdy,
    output logic [NUM_R-1:0]    rd_rsp_vld,
    output logic [NUM_R*W-1:0]  rd_rsp_data,
    input  logic [NUM_R-1:0]    rd_rsp_rdy,
    input  logic [NUM_W-1:0]    wr_req_vld,
    input  logic [NUM_W*AW-1:0] wr_req_addr,
    input  logic [NUM_W*W-1:0]  wr_req_data,
    output logic [NUM_W-1:0]    wr_req_rdy,
    input  logic                init_req,
    output logic                init_done,
    output logic                busy,
    output logic [NUM_R-1:0]    mem_ren,
    output logic [NUM_R*AW-1:0] mem_raddr,
    input  logic [NUM_R*W-1:0]  mem_rdata,
    output logic [NUM_W-1:0]    mem_wen,
    output logic [NUM_W*AW-1:0] mem_waddr,
    output logic [NUM_W*W-1:0]  mem_wdata,
    output logic                mem_init,
    input  logic                mem_busy_w
);

    client_state_t    r_state;
    logic             r_busy;
    logic             r_mem_init;
    logic             r_init_done;
    logic             r_wait_seen;
    logic [NUM_R-1:0] r_inflight;

    logic             w_accept_ok;
    logic [NUM_R-1:0] w_rd_rdy;
    logic [NUM_R-1:0] w_pop;
    logic [NUM_W-1:0] w_wr_rdy;
    logic [1:0]       w_occ [NUM_R];

    // Requests are blocked already in the cycle init_req is seen, so nothing new issues into DRAIN.
    assign w_accept_ok = (r_state == IDLE) && !init_req && !mem_busy_w && !rst;

    generate
        for (genvar p = 0; p < NUM_R; p++) begin : g_rd
            assign w_pop[p]    = rd_rsp_vld[p] && rd_rsp_rdy[p];
            assign w_rd_rdy[p] = w_accept_ok &&
                (({1'b0, w_occ[p]} + {2'b00, r_inflight[p]} - {2'b00, w_pop[p]}) < 3'd2);

            mp_client_rsp_fifo #(.W(W)) u_rsp_fifo (
                .clk    (clk),
                .rst    (rst),
                .i_push (r_inflight[p]),
                .i_din  (mem_rdata[p*W +: W]),
                .i_pop  (w_pop[p]),
                .o_vld  (rd_rsp_vld[p]),
                .o_dout (rd_rsp_data[p*W +: W]),
                .o_occ  (w_occ[p])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) r_inflight <= '0;
        else     r_inflight <= mem_ren;
    end

    // Lowest-index write port wins an address collision; the loser retries.
    always_comb begin
        w_wr_rdy = '0;
        for (int unsigned j = 0; j < NUM_W; j++) begin
            w_wr_rdy[j] = w_accept_ok;
            for (int unsigned i = 0; i < j; i++) begin
                if (wr_req_vld[i] && (wr_req_addr[i*AW +: AW] == wr_req_addr[j*AW +: AW]))
                    w_wr_rdy[j] = 1'b0;
            end
        end
    end

    assign rd_req_rdy = w_rd_rdy;
    assign mem_ren    = rd_req_vld & w_rd_rdy;
    assign mem_raddr  = rd_req_addr;
    assign wr_req_rdy = w_wr_rdy;
    assign mem_wen    = wr_req_vld & w_wr_rdy;
    assign mem_waddr  = wr_req_addr;
    assign mem_wdata  = wr_req_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_mem_init  <= 1'b0;
            r_init_done <= 1'b0;
            r_wait_seen <= 1'b0;
        end else begin
            r_mem_init  <= 1'b0;
            r_init_done <= 1'b0;
            case (r_state)
                IDLE: if (init_req) begin
                    r_state <= DRAIN;
                    r_busy  <= 1'b1;
                end
                DRAIN: if (r_inflight == '0) begin
                    r_state    <= KICK;
                    r_mem_init <= 1'b1;
                end
                KICK: begin
                    r_state     <= WAIT;
                    r_wait_seen <= 1'b0;
                end
                WAIT: begin
                    r_wait_seen <= 1'b1;
                    if (r_wait_seen && !mem_busy_w) begin
                        r_state     <= DONE;
                        r_init_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign mem_init  = r_mem_init;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_multi_ported_mem_client_3r3w.sv
// Directed bench for the 3R3W memory client with a behavioural memory, a
// per-port expected-response queue and a monitor that checks every consumed response.
module tb_multi_ported_mem_client_3r3w;

    localparam int NUM_R = 3;
    localparam int NUM_W = 3;
    localparam int W     = 32;
    localparam int N     = 1024;
    localparam int AW    = 10;

    logic                clk;
    logic                rst;
    logic [NUM_R-1:0]    rd_req_vld;
    logic [NUM_R*AW-1:0] rd_req_addr;
    logic [NUM_R-1:0]    rd_req_rdy;
    logic [NUM_R-1:0]    rd_rsp_vld;
    logic [NUM_R*W-1:0]  rd_rsp_data;
    logic [NUM_R-1:0]    rd_rsp_rdy;
    logic [NUM_W-1:0]    wr_req_vld;
    logic [NUM_W*AW-1:0] wr_req_addr;
    logic [NUM_W*W-1:0]  wr_req_data;
    logic [NUM_W-1:0]    wr_req_rdy;
    logic                init_req;
    logic                init_done;
    logic                busy;
    logic [NUM_R-1:0]    mem_ren;
    logic [NUM_R*AW-1:0] mem_raddr;
    logic [NUM_R*W-1:0]  mem_rdata;
    logic [NUM_W-1:0]    mem_wen;
    logic [NUM_W*AW-1:0] mem_waddr;
    logic [NUM_W*W-1:0]  mem_wdata;
    logic                mem_init;
    logic                mem_busy_w;

    multi_ported_mem_client_3r3w #(.NUM_R(NUM_R), .NUM_W(NUM_W), .W(W), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req_vld  (rd_req_vld),
        .rd_req_addr (rd_req_addr),
        .rd_req_rdy  (rd_req_rdy),
        .rd_rsp_vld  (rd_rsp_vld),
        .rd_rsp_data (rd_rsp_data),
        .rd_rsp_rdy  (rd_rsp_rdy),
        .wr_req_vld  (wr_req_vld),
        .wr_req_addr (wr_req_addr),
        .wr_req_data (wr_req_data),
        .wr_req_rdy  (wr_req_rdy),
        .init_req    (init_req),
        .init_done   (init_done),
        .busy        (busy),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_init    (mem_init),
        .mem_busy_w  (mem_busy_w)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [NUM_R][$];
    logic [W-1:0] mem     [N];
    logic [W-1:0] ref_mem [N];
    int          busy_cnt;
    logic        auto_sb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_busy_w = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural memory: registered read (old data on same-address write), init busy for 3 cycles.
    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i]     = 32'h5A00_0000 + i;
            ref_mem[i] = 32'h5A00_0000 + i;
        end
        mem_rdata = '0;
        busy_cnt  = 0;
        forever begin
            @(posedge clk);
            for (int p = 0; p < NUM_R; p++)
                if (mem_ren[p]) mem_rdata[p*W +: W] <= mem[mem_raddr[p*AW +: AW]];
            for (int j = 0; j < NUM_W; j++)
                if (mem_wen[j]) mem[mem_waddr[j*AW +: AW]] <= mem_wdata[j*W +: W];
            if (mem_init)          busy_cnt <= 3;
            else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end
    end

    // Reference image built from bench-side request inputs; feeds expectations in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (auto_sb)
                    for (int p = 0; p < NUM_R; p++)
                        if (rd_req_vld[p] && rd_req_rdy[p])
                            exp_q[p].push_back(ref_mem[rd_req_addr[p*AW +: AW]]);
                for (int j = 0; j < NUM_W; j++)
                    if (wr_req_vld[j] && wr_req_rdy[j])
                        ref_mem[wr_req_addr[j*AW +: AW]] <= wr_req_data[j*W +: W];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < NUM_R; p++) begin
                    if (rd_rsp_vld[p] && rd_rsp_rdy[p]) begin
                        if (exp_q[p].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL rsp_unexpected_p%0d: got %h expected no response",
                                     p, rd_rsp_data[p*W +: W]);
                        end else begin
                            check($sformatf("rsp_data_p%0d", p), rd_rsp_data[p*W +: W], exp_q[p].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && c < 50) begin
            tick();
            c++;
        end
        check(name, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [4:0]  t2_pat;
        logic [23:0] t4_tab;
        logic        got;
        logic        seen_done;
        int          acc;
        int          stalls;
        int          base;
        logic [AW-1:0] a [6];

        auto_sb     = 1'b0;
        rst         = 1'b1;
        init_req    = 1'b0;
        rd_req_vld  = '1;
        rd_req_addr = '0;
        rd_rsp_rdy  = '1;
        wr_req_vld  = '1;
        wr_req_addr = '0;
        wr_req_data = '0;
        tick();
        tick();
        check("rst_rd_rdy",   rd_req_rdy, 0);
        check("rst_wr_rdy",   wr_req_rdy, 0);
        check("rst_mem_ren",  mem_ren, 0);
        check("rst_mem_wen",  mem_wen, 0);
        check("rst_rsp_vld",  rd_rsp_vld, 0);
        check("rst_busy",     busy, 0);
        check("rst_init",     mem_init, 0);
        check("rst_done",     init_done, 0);
        rd_req_vld = '0;
        wr_req_vld = '0;
        rst        = 1'b0;
        tick();

        // 1: write then read, 2-cycle response latency
        wr_req_vld[0] = 1'b1;
        wr_req_addr[0 +: AW] = 10'h010;
        wr_req_data[0 +: W]  = 32'hDEAD_BEEF;
        #1 check("t1_wr_rdy", wr_req_rdy[0], 1);
        tick();
        wr_req_vld[0] = 1'b0;
        rd_req_vld[0] = 1'b1;
        rd_req_addr[0 +: AW] = 10'h010;
        exp_q[0].push_back(32'hDEAD_BEEF);
        #1 check("t1_rd_rdy", rd_req_rdy[0], 1);
        tick();
        rd_req_vld[0] = 1'b0;
        #1 check("t1_vld_lat1", rd_rsp_vld[0], 0);
        tick();
        #1 check("t1_vld_lat2", rd_rsp_vld[0], 1);
        wait_drain("t1_drain");

        // 2: back-pressure on port 1 caps acceptance at two
        rd_rsp_rdy[1] = 1'b0;
        t2_pat = 5'b00011;
        for (int k = 0; k < 5; k++) exp_q[1].push_back(32'h5A00_0020 + k);
        acc = 0;
        for (int c = 0; c < 40 && acc < 5; c++) begin
            if (c == 5) rd_rsp_rdy[1] = 1'b1;
            rd_req_vld[1] = 1'b1;
            rd_req_addr[AW +: AW] = 10'h020 + 10'(acc);
            #1 got = rd_req_rdy[1];
            if (c < 5) check($sformatf("t2_rdy_c%0d", c), got, t2_pat[c]);
            if (got) acc++;
            tick();
        end
        rd_req_vld[1] = 1'b0;
        check("t2_accepted", acc, 5);
        wait_drain("t2_drain");

        // 3: write collision on 0x3FF between ports 0 and 2
        wr_req_vld = 3'b101;
        wr_req_addr[0 +: AW]    = 10'h3FF;
        wr_req_addr[AW +: AW]   = 10'h000;
        wr_req_addr[2*AW +: AW] = 10'h3FF;
        wr_req_data[0 +: W]     = 32'h1111_AAAA;
        wr_req_data[2*W +: W]   = 32'h2222_BBBB;
        #1 check("t3_rdy_collide", wr_req_rdy, 3'b011);
        tick();
        wr_req_vld = 3'b100;
        rd_req_vld[1] = 1'b1;
        rd_req_addr[AW +: AW] = 10'h3FF;
        exp_q[1].push_back(32'h1111_AAAA);
        #1 check("t3_rdy_retry", wr_req_rdy, 3'b111);
        tick();
        wr_req_vld = '0;
        rd_req_vld = 3'b100;
        rd_req_addr[2*AW +: AW] = 10'h3FF;
        exp_q[2].push_back(32'h2222_BBBB);
        tick();
        rd_req_vld = '0;
        wait_drain("t3_drain");

        // 4: init sequence with two reads in flight; table holds {busy,mem_init,init_done}
        rd_req_vld = 3'b101;
        rd_req_addr[0 +: AW]    = 10'h030;
        rd_req_addr[2*AW +: AW] = 10'h031;
        exp_q[0].push_back(32'h5A00_0030);
        exp_q[2].push_back(32'h5A00_0031);
        tick();
        rd_req_vld = 3'b001;
        init_req   = 1'b1;
        #1;
        check("t4_rd_rdy_drop", rd_req_rdy, 0);
        check("t4_wr_rdy_drop", wr_req_rdy, 0);
        check("t4_busy_idle", busy, 0);
        t4_tab = {3'b000, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b100};
        for (int k = 0; k < 8; k++) begin
            tick();
            init_req   = 1'b0;
            rd_req_vld = '0;
            #1 check($sformatf("t4_status_c%0d", k + 2), {busy, mem_init, init_done}, t4_tab[k*3 +: 3]);
        end
        check("t4_rdy_back", rd_req_rdy, 3'b111);
        wait_drain("t4_drain");

        // 5: reset while port 1 FIFO is full and FSM waits on memory init
        rd_rsp_rdy[1] = 1'b0;
        rd_req_vld[1] = 1'b1;
        rd_req_addr[AW +: AW] = 10'h040;
        #1 check("t5_rdy_a", rd_req_rdy[1], 1);
        tick();
        rd_req_addr[AW +: AW] = 10'h041;
        #1 check("t5_rdy_b", rd_req_rdy[1], 1);
        tick();
        rd_req_vld[1] = 1'b0;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        tick();
        tick();
        #1;
        check("t5_wait_busy", busy, 1);
        check("t5_fifo_full", rd_rsp_vld[1], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_rsp_vld", rd_rsp_vld, 0);
        check("t5_busy", busy, 0);
        check("t5_done", init_done, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (init_done) seen_done = 1'b1;
        end
        check("t5_no_done", seen_done, 0);
        rd_rsp_rdy[1] = 1'b1;

        // 6: all ports busy every cycle, distinct addresses
        for (int k = 0; k < 10 && mem_busy_w; k++) tick();
        check("t6_mem_idle", mem_busy_w, 0);
        stalls  = 0;
        auto_sb = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            base = $urandom_range(0, N - 1);
            for (int k = 0; k < 6; k++) a[k] = AW'((base + k * 37) % N);
            for (int p = 0; p < NUM_R; p++) rd_req_addr[p*AW +: AW] = a[p];
            for (int j = 0; j < NUM_W; j++) begin
                wr_req_addr[j*AW +: AW] = a[3 + j];
                wr_req_data[j*W +: W]   = $urandom;
            end
            rd_req_vld = '1;
            wr_req_vld = '1;
            #1;
            if (rd_req_rdy != 3'b111 || wr_req_rdy != 3'b111) stalls++;
            tick();
        end
        rd_req_vld = '0;
        wr_req_vld = '0;
        auto_sb    = 1'b0;
        check("t6_stalls", stalls, 0);
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
